// File: rtl/accumulator_drain.sv
// rtl/accumulator_drain.sv - accumulator bank reader: ReLU, shift requant, saturate, stream out
// Reads rows in write order, pushes them through a credit-guarded skid FIFO, emits with backpressure.
module accumulator_drain #(
  parameter int LANES  = 32,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [8:0]               H_DIM_i,
  input  logic [8:0]               W_DIM_i,
  input  logic [4:0]               shift_i,
  output logic                     accum_rd_en_o,
  output logic [ADDR_W-1:0]        accum_rd_addr_o,
  input  logic [LANES*ACC_W-1:0]   accum_rd_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES*OUT_W-1:0]   out_data_o,
  output logic                     out_tile_last_o,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int D  = RD_LAT + 2;
  localparam int CW = $clog2(D + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int DW = LANES * OUT_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [OUT_W-1:0]        SAT_OUT = OUT_W'((1 << (OUT_W - 1)) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [9:0]          r_rows, r_row_cnt;
  logic [4:0]          r_tiles, r_tile_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [4:0]          r_shift;
  logic [CW-1:0]       r_inflight, r_count;
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [RD_LAT-1:0]   r_pipe_vld, r_pipe_tl, r_pipe_l;
  logic [DW+1:0]       r_mem [D];

  logic [9:0]          w_rows_in;
  logic [4:0]          w_tiles_in;
  logic                w_pop, w_push, w_rd_en, w_row_last, w_job_last;
  logic [CW:0]         w_used;
  logic [CW-1:0]       w_inflight_nxt, w_count_nxt;
  logic [DW-1:0]       w_q;
  logic [DW+1:0]       w_head;

  assign w_rows_in  = ((10'(H_DIM_i) >> 5) + 10'd1) << 5;
  assign w_tiles_in = 5'((10'(W_DIM_i) >> 5) + 10'd1);

  assign w_pop  = (r_count != '0) & out_ready_i;
  assign w_push = r_pipe_vld[RD_LAT-1];

  // Rows in flight plus rows parked in the FIFO never exceed the FIFO depth.
  assign w_used  = (CW+1)'(r_inflight) + (CW+1)'(r_count) - (CW+1)'(w_pop);
  assign w_rd_en = (r_state == S_ISSUE) && (w_used < (CW+1)'(D));

  assign w_row_last = (r_row_cnt == r_rows - 10'd1);
  assign w_job_last = w_row_last && (r_tile_cnt == r_tiles - 5'd1);

  assign w_inflight_nxt = r_inflight + CW'(w_rd_en) - CW'(w_push);
  assign w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_rd_en && w_job_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_inflight_nxt == '0 && w_count_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    logic signed [ACC_W-1:0] w_lane, w_relu, w_shr;
    w_q    = '0;
    w_lane = '0;
    w_relu = '0;
    w_shr  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane = $signed(accum_rd_data_i[i*ACC_W +: ACC_W]);
      w_relu = w_lane[ACC_W-1] ? '0 : w_lane;
      w_shr  = w_relu >>> r_shift;
      w_q[i*OUT_W +: OUT_W] = (w_shr > SAT_MAX) ? SAT_OUT : w_shr[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_rows     <= '0;
      r_tiles    <= '0;
      r_row_cnt  <= '0;
      r_tile_cnt <= '0;
      r_addr     <= '0;
      r_shift    <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pipe_vld <= '0;
      r_pipe_tl  <= '0;
      r_pipe_l   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start_i) begin
        r_rows     <= w_rows_in;
        r_tiles    <= w_tiles_in;
        r_shift    <= shift_i;
        r_row_cnt  <= '0;
        r_tile_cnt <= '0;
        r_addr     <= '0;
      end else if (w_rd_en) begin
        // The address is the linear row index x*R + r, so it simply counts.
        r_addr <= r_addr + 1'b1;
        if (w_row_last) begin
          r_row_cnt  <= '0;
          r_tile_cnt <= r_tile_cnt + 5'd1;
        end else begin
          r_row_cnt <= r_row_cnt + 10'd1;
        end
      end
      r_inflight <= w_inflight_nxt;
      r_count    <= w_count_nxt;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tl[i]  <= r_pipe_tl[i-1];
        r_pipe_l[i]   <= r_pipe_l[i-1];
      end
      r_pipe_vld[0] <= w_rd_en;
      r_pipe_tl[0]  <= w_row_last;
      r_pipe_l[0]   <= w_job_last;
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(D - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(D - 1)) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_pipe_tl[RD_LAT-1], r_pipe_l[RD_LAT-1], w_q};
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign out_valid_o     = (r_count != '0);
  assign out_data_o      = out_valid_o ? w_head[DW-1:0] : '0;
  assign out_tile_last_o = out_valid_o & w_head[DW+1];
  assign out_last_o      = out_valid_o & w_head[DW];
  assign accum_rd_en_o   = w_rd_en;
  assign accum_rd_addr_o = r_addr;
  assign busy_o          = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done_o          = (r_state == S_DONE);

endmodule

// File: tb/tb_accumulator_drain.sv
// tb/tb_accumulator_drain.sv - self-checking bench for accumulator_drain
// Table vectors for the lane datapath, directed timing/reset/restart sequences, random jobs vs a row model.
module tb_accumulator_drain;
  localparam int LANES = 32, ACC_W = 32, OUT_W = 8, ADDR_W = 7, RD_LAT = 1;
  localparam int DW = LANES * OUT_W;
  localparam int AW = LANES * ACC_W;

  logic                clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [8:0]          H_DIM_i = '0, W_DIM_i = '0;
  logic [4:0]          shift_i = '0;
  logic                accum_rd_en_o;
  logic [ADDR_W-1:0]   accum_rd_addr_o;
  logic [AW-1:0]       accum_rd_data_i = '0;
  logic                out_valid_o, out_ready_i = 1'b0;
  logic [DW-1:0]       out_data_o;
  logic                out_tile_last_o, out_last_o, busy_o, done_o;

  accumulator_drain #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .H_DIM_i(H_DIM_i), .W_DIM_i(W_DIM_i),
    .shift_i(shift_i), .accum_rd_en_o(accum_rd_en_o), .accum_rd_addr_o(accum_rd_addr_o),
    .accum_rd_data_i(accum_rd_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_tile_last_o(out_tile_last_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  logic [AW-1:0] acc_mem [0:127];
  always @(posedge clk_i) if (accum_rd_en_o) accum_rd_data_i <= acc_mem[accum_rd_addr_o];

  typedef struct { logic [DW-1:0] data; logic tl; logic l; } row_t;
  typedef struct { logic [31:0] a; int sh; logic [7:0] expv; } vec_t;

  row_t exp_q[$];
  vec_t tbl[16];
  int n_cmp = 0, n_bad = 0;
  int exp_idx, exp_total, n_reads, n_pops, n_done, t0, mode;
  int first_rd, first_val, last_pop, done_rel, mon_rel;
  logic busy_at1, mon_en = 1'b0, hold_pend, mon_pop;
  logic [DW-1:0] hold_data, row0;
  logic [1:0] hold_flags;
  row_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [OUT_W-1:0] quant(input logic [ACC_W-1:0] a, input int sh);
    longint v;
    v = longint'($signed(a));
    if (v < 0) v = 0;
    v = v / (longint'(1) << sh);
    if (v > 127) v = 127;
    return OUT_W'(v);
  endfunction

  function automatic logic [DW-1:0] quant_row(input logic [AW-1:0] acc, input int sh);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*OUT_W +: OUT_W] = quant(acc[l*ACC_W +: ACC_W], sh);
    return r;
  endfunction

  task automatic fill_mem();
    for (int a = 0; a < 128; a++)
      for (int l = 0; l < LANES; l++)
        case ($urandom_range(0, 3))
          0: acc_mem[a][l*ACC_W +: ACC_W] = $urandom;
          1: acc_mem[a][l*ACC_W +: ACC_W] = 32'(-int'($urandom_range(1, 600)));
          default: acc_mem[a][l*ACC_W +: ACC_W] = $urandom_range(0, 2000);
        endcase
  endtask

  task automatic drive_ready();
    case (mode)
      0: out_ready_i = 1'b1;
      1: out_ready_i = ($urandom_range(0, 99) < 30);
      default: out_ready_i = ($urandom_range(0, 99) < 50);
    endcase
  endtask

  // Job model: rows in linear order, address wraps mod 128, tile flag every R rows.
  task automatic start_job(input int h, input int w, input int sh, input int md);
    int rr, tt;
    row_t e;
    rr = ((h / 32) + 1) * 32;
    tt = (w / 32) + 1;
    exp_q.delete();
    for (int i = 0; i < rr * tt; i++) begin
      e.data = quant_row(acc_mem[i % 128], sh);
      e.tl = (i % rr) == rr - 1;
      e.l  = (i == rr * tt - 1);
      exp_q.push_back(e);
    end
    exp_total = rr * tt;
    exp_idx = 0; n_reads = 0; n_pops = 0; n_done = 0; hold_pend = 1'b0;
    first_rd = -1; first_val = -1; last_pop = -1; done_rel = -1; busy_at1 = 1'b0;
    mode = md;
    @(posedge clk_i); #1;
    start_i = 1'b1; H_DIM_i = 9'(h); W_DIM_i = 9'(w); shift_i = 5'(sh);
    t0 = cyc; mon_en = 1'b1;
    drive_ready();
    @(posedge clk_i); #1;
    start_i = 1'b0; H_DIM_i = 9'($urandom); W_DIM_i = 9'($urandom); shift_i = 5'($urandom);
    drive_ready();
  endtask

  task automatic finish_job(input int mid, input int budget);
    for (int k = 0; k < budget && n_done == 0; k++) begin
      @(posedge clk_i); #1;
      drive_ready();
      start_i = (k == mid);
    end
    start_i = 1'b0;
    repeat (4) begin @(posedge clk_i); #1; drive_ready(); end
    chk("done_count", n_done, 1);
    chk("rows_left", exp_q.size(), 0);
    chk("reads", n_reads, exp_total);
    chk("pops", n_pops, exp_total);
    chk("busy_after", busy_o, 0);
    mon_en = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      mon_rel = cyc - t0;
      mon_pop = out_valid_o && out_ready_i;
      chk("outstanding", (n_reads - n_pops) <= 3, 1);
      if (hold_pend) begin
        chk("hold_valid", out_valid_o, 1);
        chk_vec("hold_data", out_data_o, hold_data);
        chk("hold_flags", {out_tile_last_o, out_last_o}, hold_flags);
      end
      hold_pend = out_valid_o && !out_ready_i;
      hold_data = out_data_o;
      hold_flags = {out_tile_last_o, out_last_o};
      if (accum_rd_en_o) begin
        chk("credit", (n_reads - n_pops - int'(mon_pop)) < 3, 1);
        chk("rd_addr", accum_rd_addr_o, exp_idx % 128);
        chk("rd_in_job", exp_idx < exp_total, 1);
        if (first_rd < 0) first_rd = mon_rel;
        exp_idx++;
        n_reads++;
      end
      if (mon_rel == 1) busy_at1 = busy_o;
      if (mon_pop) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_row: got row %0d expected at most %0d rows", n_pops + 1, exp_total);
        end else begin
          mon_e = exp_q.pop_front();
          chk_vec("row_data", out_data_o, mon_e.data);
          chk("tile_last", out_tile_last_o, mon_e.tl);
          chk("last", out_last_o, mon_e.l);
        end
        if (n_pops == 0) begin row0 = out_data_o; first_val = mon_rel; end
        last_pop = mon_rel;
        n_pops++;
      end
      if (done_o) begin n_done++; done_rel = mon_rel; end
    end
  end

  initial begin
    int seen_done, seen_valid, hsel, tt, hh, ww;
    tbl[0]  = '{32'hFFFF_FFFB, 2, 8'd0};
    tbl[1]  = '{32'd300, 2, 8'd75};
    tbl[2]  = '{32'd508, 2, 8'd127};
    tbl[3]  = '{32'd1000, 2, 8'd127};
    tbl[4]  = '{32'h7FFF_FFFF, 2, 8'd127};
    tbl[5]  = '{32'd1000, 3, 8'd125};
    tbl[6]  = '{32'd127, 0, 8'd127};
    tbl[7]  = '{32'd128, 0, 8'd127};
    tbl[8]  = '{32'hFFFF_FFFF, 0, 8'd0};
    tbl[9]  = '{32'd0, 7, 8'd0};
    tbl[10] = '{32'd255, 1, 8'd127};
    tbl[11] = '{32'd253, 1, 8'd126};
    tbl[12] = '{32'h8000_0000, 5, 8'd0};
    tbl[13] = '{32'h7FFF_FFFF, 31, 8'd0};
    tbl[14] = '{32'd4064, 5, 8'd127};
    tbl[15] = '{32'd4096, 6, 8'd64};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_rd_en", accum_rd_en_o, 0);
    chk("rst_addr", accum_rd_addr_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk_vec("rst_data", out_data_o, '0);
    rst_i = 1'b0;

    // Basic single-tile job with timing landmarks.
    fill_mem();
    start_job(31, 31, 0, 0);
    finish_job(-1, 200);
    chk("first_rd_cycle", first_rd, 1);
    chk("busy_cycle1", busy_at1, 1);
    chk("first_valid_cycle", first_val, 3);
    chk("last_valid_cycle", last_pop, 34);
    chk("done_cycle", done_rel, 35);

    // Lane datapath vectors broadcast across row 0.
    for (int i = 0; i < 16; i++) begin
      fill_mem();
      for (int l = 0; l < LANES; l++) acc_mem[0][l*ACC_W +: ACC_W] = tbl[i].a;
      start_job(31, 31, tbl[i].sh, 0);
      finish_job(-1, 200);
      chk_vec($sformatf("vec%0d_row0", i), row0, {LANES{tbl[i].expv}});
    end

    // Two tiles of 64 rows, full rate.
    fill_mem();
    start_job(63, 63, $urandom_range(0, 12), 0);
    finish_job(-1, 400);

    // Same geometry with a sparse ready pattern.
    fill_mem();
    start_job(63, 63, $urandom_range(0, 12), 1);
    finish_job(-1, 4000);

    // Second start pulse mid-job is ignored.
    fill_mem();
    start_job(63, 63, 3, 2);
    finish_job(10, 4000);

    // Random geometries within the 128-row address space.
    repeat (4) begin
      hsel = $urandom_range(0, 3);
      tt = $urandom_range(1, 4 / (hsel + 1));
      hh = hsel * 32 + $urandom_range(0, 31);
      ww = (tt - 1) * 32 + $urandom_range(0, 31);
      fill_mem();
      start_job(hh, ww, $urandom_range(0, 20), $urandom_range(0, 2));
      finish_job(-1, 4000);
    end

    // Reset in the middle of ISSUE abandons the job.
    fill_mem();
    start_job(63, 63, 1, 2);
    repeat (20) begin @(posedge clk_i); #1; drive_ready(); end
    mon_en = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("mrst_rd_en", accum_rd_en_o, 0);
    chk("mrst_addr", accum_rd_addr_o, 0);
    chk("mrst_valid", out_valid_o, 0);
    chk("mrst_flags", {out_tile_last_o, out_last_o}, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_done", done_o, 0);
    chk_vec("mrst_data", out_data_o, '0);
    seen_done = 0; seen_valid = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;
      if (done_o) seen_done++;
      if (out_valid_o) seen_valid++;
    end
    chk("mrst_no_done", seen_done, 0);
    chk("mrst_no_valid", seen_valid, 0);
    fill_mem();
    start_job(63, 63, 4, 1);
    finish_job(-1, 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/accumulator_drain.md
# accumulator_drain

Reads finished results out of the accumulator bank after the control unit signals the end of a matrix job, and streams them to the unified/output buffer. The block is the reader side of the accumulator write interface: the control unit writes rows at address `x_tile*R + row`, and this block reads them back in the same order. On each row it applies ReLU, an arithmetic right-shift requantization and signed saturation, then emits the row over a valid/ready stream with backpressure.

## Interface
Parameters:
- LANES, 32, accumulator lanes per row (systolic array width)
- ACC_W, 32, accumulator lane width (signed)
- OUT_W, 8, output lane width (signed)
- ADDR_W, 7, accumulator address width
- RD_LAT, 1, accumulator read latency in cycles (fixed, ≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  one-cycle job-complete pulse (driven by control unit done_o)
- H_DIM_i  in  9  activation rows minus 1, as given to the control unit
- W_DIM_i  in  9  weight columns minus 1, as given to the control unit
- shift_i  in  5  requantization right-shift, sampled at accepted start
- accum_rd_en_o  out  1  accumulator read strobe
- accum_rd_addr_o  out  ADDR_W  accumulator read address
- accum_rd_data_i  in  LANES*ACC_W  read data, valid RD_LAT cycles after strobe; lane i at bits [i*ACC_W +: ACC_W]
- out_valid_o  out  1  output row valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  LANES*OUT_W  quantized row; lane i at [i*OUT_W +: OUT_W]
- out_tile_last_o  out  1  row is the last row of a column tile
- out_last_o  out  1  row is the last row of the job
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse when the job has fully drained

## Operation
- Geometry is latched at an accepted start:
  - R = ((H_DIM_i>>5)+1)<<5 rows per column tile.
  - T = (W_DIM_i>>5)+1 column tiles.
  - Job = R*T rows.
  - Address = x*R + r, truncated to ADDR_W. R*T > 2^ADDR_W is a usage error; addresses wrap and this is not checked.
- Counters: r runs 0..R-1; x runs 0..T-1; r wraps to 0 and x increments when r reaches R-1.
- FSM:
  - IDLE: busy_o=0. On start_i, latch geometry and shift, clear counters, go to ISSUE.
  - ISSUE: assert accum_rd_en_o when a credit is available. After issuing the final address, go to DRAIN.
  - DRAIN: wait until in-flight reads = 0 and the FIFO is empty, then go to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- start_i in any state other than IDLE is ignored.
- Credit flow:
  - Skid FIFO depth D = RD_LAT+2.
  - Read issued only if inflight + occupancy − pop_this_cycle < D, where pop = out_valid_o & out_ready_i.
  - The FIFO therefore never overflows and read data is never dropped.
- Per-lane datapath, combinational between accum_rd_data_i and the FIFO write:
  - v = (a<0) ? 0 : a
  - q = v >>> shift
  - out = (q > 2^(OUT_W−1)−1) ? 2^(OUT_W−1)−1 : q
- Tag bits out_tile_last and out_last travel with each read through a RD_LAT-deep delay line and are stored with the row.
- out_data_o / flags are held stable while out_valid_o=1 and out_ready_i=0.

## Timing
- Reset: all outputs 0, FSM=IDLE, FIFO empty, inflight=0, counters=0. Reset mid-job abandons the job and emits no done_o. Data returning after reset is discarded.
- start_i at cycle 0 → busy_o=1 and first accum_rd_en_o (addr 0) at cycle 1.
- Read at cycle t → row captured in FIFO at end of t+RD_LAT → out_valid_o at t+RD_LAT+1. First out_valid_o is at cycle 2+RD_LAT.
- With out_ready_i held 1: one read and one output per cycle, no bubbles.
- Handshake: a row transfers on a cycle with valid & ready. out_valid_o does not depend combinationally on out_ready_i.
- done_o is asserted the cycle after the handshake of the out_last_o row. busy_o drops in the same cycle done_o is asserted.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

## Test plan
- H=31, W=31, shift=0, ready=1, RD_LAT=1 → addresses 0..31 on consecutive cycles from cycle 1; out_valid_o cycles 3..34; out_last_o and out_tile_last_o on row 31; done_o at cycle 35.
- H=63, W=63 → R=64, T=2, 128 reads at addresses 0..127; out_tile_last_o on rows 63 and 127; out_last_o on row 127 only.
- Lane values −5, 300, 508, 1000, 2^31−1 with shift=2 → outputs 0, 75, 127, 127, 127.
- out_ready_i driven by a random 30% duty pattern on a 128-row job → every address read exactly once, in order; rows match the model; no loss or duplication; accum_rd_en_o never asserted with zero credits; inflight+occupancy ≤ 3.
- start_i pulsed again mid-job → ignored; address sequence and done_o count unchanged (one done_o).
- rst_i asserted for one cycle mid-ISSUE → next cycle all outputs 0, no done_o; a new start_i then runs a full job correctly from address 0.
